// File: rtl/softmax_pkg.sv
// Shared constants and types for the softmax normalisation stage.
// SUM_BW/SUM_FW describe the reduced sum produced by the reduction tree and
// must match that stage. Reciprocal is unsigned Q0.RECIP_BW.
package softmax_pkg;

  localparam int unsigned IN_FW        = 15;
  localparam int unsigned SUM_BW       = 16;
  localparam int unsigned SUM_FW       = 6;
  localparam int unsigned RECIP_BW     = 16;
  localparam int unsigned DIV_CYCLES   = RECIP_BW + SUM_FW + 1;
  localparam int unsigned VEC_SIZE_DEF = 5;
  localparam int unsigned IDX_W        = $clog2(VEC_SIZE_DEF);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    EMIT
  } norm_state_t;

endpackage

// File: rtl/softmax_normalize_recip_div_seq.sv
// recip_div_seq: sequential restoring divider computing
//   quotient = 2^(RECIP_BW+SUM_FW) / divisor, saturated to RECIP_BW bits.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   start       load divisor and begin (takes priority over a running division)
//   divisor     SUM_BW-bit unsigned divisor
//   busy        division in progress
//   done        one-cycle pulse when quotient is final
//   quotient    saturated reciprocal, held until the next start
//   dz          divisor was zero (quotient forced to all ones)
module recip_div_seq
  import softmax_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SUM_BW-1:0]   divisor,
  output logic                busy,
  output logic                done,
  output logic [RECIP_BW-1:0] quotient,
  output logic                dz
);

  localparam int unsigned CW = $clog2(DIV_CYCLES);

  logic                  busy_q, done_q, dz_q;
  logic [CW-1:0]         cnt_q;
  logic [SUM_BW:0]       rem_q, rem_d;
  logic [SUM_BW+1:0]     rem_sh, div_ext;
  logic [DIV_CYCLES-1:0] quo_q, quo_d;
  logic [SUM_BW-1:0]     div_q;
  logic                  ge;

  // The dividend is a single 1 at its MSB, so only the first step shifts in a 1.
  always_comb begin
    rem_sh  = {rem_q, (cnt_q == '0)};
    div_ext = {2'b00, div_q};
    ge      = (rem_sh >= div_ext);
    rem_d   = ge ? (SUM_BW+1)'(rem_sh - div_ext) : (SUM_BW+1)'(rem_sh);
    quo_d   = {quo_q[DIV_CYCLES-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      done_q <= 1'b0;
      dz_q   <= (divisor == '0);
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= divisor;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == CW'(DIV_CYCLES - 1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign dz       = dz_q;
  assign quotient = (dz_q || (|quo_q[DIV_CYCLES-1:RECIP_BW])) ? '1 : quo_q[RECIP_BW-1:0];

endmodule

// File: rtl/softmax_normalize.sv
// softmax_normalize: latches an exponent vector and its reduced sum, derives
// R = 1/sum with recip_div_seq, then streams y_i = (x_i * R) >> RECIP_BW one
// element per output handshake, index order 0..VEC_SIZE-1.
// Ports:
//   clk, rst_n            clock / async active-low reset
//   in_valid, in_ready    input handshake (vector + sum)
//   vec_in, sum_in        exponent vector and its sum
//   out_valid, out_ready  output handshake
//   out_data, out_idx     normalised element and its index (registered)
//   out_last              out_idx == VEC_SIZE-1
//   div_by_zero           latched sum was zero, held for the whole vector
module softmax_normalize
  import softmax_pkg::*;
#(
  parameter int unsigned VEC_SIZE = VEC_SIZE_DEF,
  parameter int unsigned IN_BW    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_BW-1:0]            vec_in [VEC_SIZE],
  input  logic [SUM_BW-1:0]           sum_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IN_BW-1:0]            out_data,
  output logic [$clog2(VEC_SIZE)-1:0] out_idx,
  output logic                        out_last,
  output logic                        div_by_zero
);

  localparam int unsigned IW = $clog2(VEC_SIZE);
  localparam int unsigned PW = IN_BW + RECIP_BW;

  norm_state_t           state_q, state_d;
  logic [IN_BW-1:0]      vec_q [VEC_SIZE];
  logic [IN_BW-1:0]      vec_d [VEC_SIZE];
  logic [IW-1:0]         idx_q, idx_d, next_idx;
  logic [IN_BW-1:0]      data_q, data_d;
  logic                  last_q, last_d;
  logic                  dbz_q, dbz_d;
  logic                  div_start, div_busy, div_done, div_dz;
  logic [RECIP_BW-1:0]   recip;

  function automatic logic [IN_BW-1:0] scale(input logic [IN_BW-1:0] x,
                                             input logic [RECIP_BW-1:0] r);
    logic [PW-1:0] p;
    p = PW'(x) * PW'(r);
    return IN_BW'(p >> RECIP_BW);
  endfunction

  recip_div_seq u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .divisor  (sum_in),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (recip),
    .dz       (div_dz)
  );

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    idx_d     = idx_q;
    data_d    = data_q;
    last_d    = last_q;
    dbz_d     = dbz_q;
    div_start = 1'b0;
    next_idx  = idx_q + IW'(1);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          vec_d     = vec_in;
          div_start = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: begin
        if (div_done && !div_busy) begin
          state_d = EMIT;
          idx_d   = '0;
          data_d  = scale(vec_q[0], recip);
          last_d  = (VEC_SIZE == 1);
          dbz_d   = div_dz;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            idx_d   = '0;
            data_d  = '0;
            last_d  = 1'b0;
            dbz_d   = 1'b0;
          end else begin
            idx_d  = next_idx;
            data_d = scale(vec_q[next_idx], recip);
            last_d = (next_idx == IW'(VEC_SIZE - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '{default: '0};
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == EMIT);
  assign out_data    = data_q;
  assign out_idx     = idx_q;
  assign out_last    = last_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/softmax_normalize.md
Name: softmax_normalize

Overview:
- Downstream consumer of the softmax exponent-sum reduction tree.
- Latches one exponent vector plus its reduced sum, computes reciprocal R = 1/sum with a sequential restoring divider, then streams normalized elements y_i = x_i * R one per handshake.
- Sits between the reduction stage and the softmax output buffer; valid/ready on both sides.

Parameters:
- VEC_SIZE, 5, elements per vector
- IN_BW, 16, element width (unsigned, IN_FW fraction bits)
- IN_FW, 15, element fraction bits
- SUM_BW, 16, reduced-sum width (unsigned)
- SUM_FW, 6, reduced-sum fraction bits
- RECIP_BW, 16, reciprocal width, unsigned Q0.RECIP_BW

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  vector + sum present
- in_ready  out  1  block can accept a new vector
- vec_in  in  [IN_BW-1:0] x VEC_SIZE  unpacked array, exponent values
- sum_in  in  SUM_BW  reduced sum of vec_in
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  IN_BW  normalized element, IN_FW fraction bits
- out_idx  out  $clog2(VEC_SIZE)  element index of out_data
- out_last  out  1  out_idx == VEC_SIZE-1
- div_by_zero  out  1  latched sum was 0; held for the whole vector

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, div_by_zero=0. All internal registers cleared.
- Reset mid-operation aborts the vector. Nothing is emitted. After release, the block is in IDLE.
- FSM: IDLE -> DIV -> EMIT -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, register vec_in and sum_in, clear the divider, go to DIV.
- DIV:
  - in_ready=0.
  - Restoring division of dividend 2^(RECIP_BW+SUM_FW) by S=sum_in.
  - One quotient bit per cycle, MSB first, for exactly DIV_CYCLES = RECIP_BW+SUM_FW+1 = 23 cycles (counter 0..22).
  - Final R = quotient, saturated to 2^RECIP_BW-1 if the quotient is >= 2^RECIP_BW.
  - If S == 0: still spend 23 cycles. R = 2^RECIP_BW-1 and div_by_zero=1.
  - Then go to EMIT with element index 0.
- EMIT:
  - out_valid=1.
  - out_data = (x_idx * R) >> RECIP_BW, truncated, a full IN_BW+RECIP_BW product. The result always fits IN_BW.
  - out_data, out_idx and out_last are registered outputs. They are stable while out_valid & !out_ready.
  - On out_valid & out_ready: if not last, idx++ and present the next element the next cycle. If last, go to IDLE; out_valid=0 and in_ready=1 the next cycle.
  - div_by_zero clears on the IDLE transition.
- Latency: the first out_valid appears 24 cycles after the input handshake cycle. Throughput is one element per cycle under out_ready=1. With continuous out_ready the block is busy for 24+VEC_SIZE cycles per vector.
- No input/output overlap: in_ready is low from the accept cycle until the cycle after the last output handshake.
- in_valid while not in IDLE is ignored. The upstream stage must hold its data.
- out_ready toggling mid-vector only stalls the stream. Index order is strictly 0..VEC_SIZE-1.

Decomposition:
- Shared package softmax_pkg holds:
  - localparams DIV_CYCLES, IDX_W
  - enum type norm_state_t {IDLE, DIV, EMIT}
  - fixed-point width constants shared with the reduction stage (SUM_BW, SUM_FW)
- One sub-module: recip_div_seq, the sequential restoring divider.
  - Ports: clk, rst_n, start, divisor, busy, done, quotient, dz.
  - Saturation is done inside it.
- Multiply and EMIT control stay in softmax_normalize.

Test Plan:
- sum_in=0x0080 (2.0), vec_in[0]=0x4000 -> R=0x8000; first out_data=0x2000, out_idx=0; first out_valid exactly 24 cycles after accept.
- sum_in=0x0140 (5.0), all vec_in=0x8000 -> R=0x3333; five outputs each 0x1999, out_last only on idx 4.
- sum_in=0x0040 (1.0, saturation), vec_in[0]=0x7FFF -> R=0xFFFF, out_data=0x7FFE, div_by_zero=0.
- sum_in=0 -> all outputs x_i*0xFFFF>>16; div_by_zero=1 for all five outputs, 0 after return to IDLE.
- out_ready held low 3 cycles at idx 2 -> out_data/out_idx stable, no skipped or duplicated index; in_valid pulses during DIV/EMIT are ignored and in_ready stays 0.
- rst_n asserted mid-DIV (cycle 10) and mid-EMIT (idx 3) -> outputs return to reset values immediately; next vector after release is processed correctly from idx 0.
